// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life generation engine: state encoding,
// board geometry and the birth/survival rule.
package life_pkg;

   typedef enum logic [1:0] {
      ST_FILL    = 2'd0,
      ST_READY   = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_COMMIT  = 2'd3
   } life_state_t;

   localparam int ROWS  = 4;
   localparam int NBRS  = 8;
   // 0..8 live neighbours needs four bits
   localparam int CNT_W = 4;

   // Number of live cells among the eight neighbours
   function automatic logic [CNT_W-1:0] nbr_count(input logic [NBRS-1:0] nbrs);
      logic [CNT_W-1:0] cnt;
      cnt = {CNT_W{1'b0}};
      for (int k = 0; k < NBRS; k++) begin
         cnt = cnt + CNT_W'(nbrs[k]);
      end
      return cnt;
   endfunction

   // Conway rule: birth on exactly 3, survival on 2 or 3
   function automatic logic life_rule(input logic alive, input logic [CNT_W-1:0] cnt);
      return (cnt == CNT_W'(3)) | (alive & (cnt == CNT_W'(2)));
   endfunction

endpackage

// File: rtl/life_cell_rule.sv
// One-cell next-state slice: eight neighbour bits plus current state in,
// next-generation state out. Purely combinational.
module life_cell_rule
   import life_pkg::*;
(
   input  logic [NBRS-1:0] i_nbrs,
   input  logic            i_alive,
   output logic            o_next
);

   logic [CNT_W-1:0] w_cnt;

   // Count live neighbours and apply the birth/survival rule
   always_comb begin
      w_cnt  = nbr_count(i_nbrs);
      o_next = life_rule(i_alive, w_cnt);
   end

endmodule

// File: rtl/life_gen_engine.sv
// Game-of-Life generation engine for a 4-row toroidal board. Rows are loaded
// from board RAM on write_array strobes, the next generation is computed one
// column per cycle on run, and each new row is written back on its write_mem
// strobe.
module life_gen_engine
   import life_pkg::*;
#(
   parameter int COLS  = 16,
   parameter int GEN_W = 16
)(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_write_array,
   input  logic             i_run,
   input  logic [1:0]       i_pos,
   input  logic             i_write_mem,
   output logic [1:0]       o_mem_addr,
   input  logic [COLS-1:0]  i_mem_rd_data,
   output logic             o_mem_wr_en,
   output logic [COLS-1:0]  o_mem_wr_data,
   output logic             o_board_valid,
   output logic             o_busy,
   output logic             o_overrun,
   output logic [GEN_W-1:0] o_gen_count
);

   localparam int COL_W = $clog2(COLS);

   life_state_t      r_state;
   logic [COLS-1:0]  r_working [ROWS];
   logic [COLS-1:0]  r_next    [ROWS];
   logic [ROWS-1:0]  r_loaded_mask;
   logic [ROWS-1:0]  r_pending;
   logic [COL_W-1:0] r_col;
   logic             r_load_pending;
   logic [1:0]       r_load_row;
   logic             r_run_hold;
   logic             r_board_valid;
   logic             r_busy;
   logic             r_overrun;
   logic [GEN_W-1:0] r_gen_count;

   logic [COL_W-1:0] w_col_l;
   logic [COL_W-1:0] w_col_r;
   logic [NBRS-1:0]  w_nbrs [ROWS];
   logic [ROWS-1:0]  w_next_col;
   logic             w_load_ok;
   logic             w_load_accept;
   logic             w_load_drop;
   logic             w_run_drop;
   logic             w_commit_hit;
   logic [ROWS-1:0]  w_pos_mask;
   logic [ROWS-1:0]  w_pending_after;

   // Toroidal left/right column neighbours of the column being computed
   always_comb begin
      if (r_col == {COL_W{1'b0}}) begin
         w_col_l = COL_W'(COLS - 1);
      end else begin
         w_col_l = r_col - COL_W'(1);
      end
      if (r_col == COL_W'(COLS - 1)) begin
         w_col_r = {COL_W{1'b0}};
      end else begin
         w_col_r = r_col + COL_W'(1);
      end
   end

   // Per-row compute slice; rows wrap 0<->3
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam int RU = (r + ROWS - 1) % ROWS;
      localparam int RD = (r + 1) % ROWS;

      assign w_nbrs[r] = {r_working[RU][w_col_l], r_working[RU][r_col], r_working[RU][w_col_r],
                          r_working[r][w_col_l],                        r_working[r][w_col_r],
                          r_working[RD][w_col_l], r_working[RD][r_col], r_working[RD][w_col_r]};

      life_cell_rule u_rule (
         .i_nbrs  (w_nbrs[r]),
         .i_alive (r_working[r][r_col]),
         .o_next  (w_next_col[r])
      );
   end

   // Strobe qualification: loads only while idle, write-back wins over a load
   always_comb begin
      w_load_ok       = (r_state == ST_FILL) | (r_state == ST_READY);
      w_load_accept   = i_write_array & ~i_write_mem & w_load_ok;
      w_load_drop     = i_write_array & (i_write_mem | ~w_load_ok);
      w_run_drop      = i_run & ((r_state == ST_COMPUTE) | (r_state == ST_COMMIT));
      w_pos_mask      = ROWS'(1) << i_pos;
      w_commit_hit    = (r_state == ST_COMMIT) & i_write_mem & r_pending[i_pos];
      if (w_commit_hit) begin
         w_pending_after = r_pending & ~w_pos_mask;
      end else begin
         w_pending_after = r_pending;
      end
   end

   // Write-back port follows the strobe in the same cycle
   always_comb begin
      o_mem_wr_en = w_commit_hit;
      if (w_commit_hit) begin
         o_mem_wr_data = r_next[i_pos];
      end else begin
         o_mem_wr_data = {COLS{1'b0}};
      end
   end

   assign o_mem_addr    = i_pos;
   assign o_board_valid = r_board_valid;
   assign o_busy        = r_busy;
   assign o_overrun     = r_overrun;
   assign o_gen_count   = r_gen_count;

   // Main sequencer: load capture, generation compute and row commit
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state        <= ST_FILL;
         r_loaded_mask  <= {ROWS{1'b0}};
         r_pending      <= {ROWS{1'b0}};
         r_col          <= {COL_W{1'b0}};
         r_load_pending <= 1'b0;
         r_load_row     <= 2'd0;
         r_run_hold     <= 1'b0;
         r_board_valid  <= 1'b0;
         r_busy         <= 1'b0;
         r_overrun      <= 1'b0;
         r_gen_count    <= {GEN_W{1'b0}};
         for (int r = 0; r < ROWS; r++) begin
            r_working[r] <= {COLS{1'b0}};
            r_next[r]    <= {COLS{1'b0}};
         end
      end else begin
         // RAM data for an accepted load arrives one cycle after the strobe
         r_load_pending <= w_load_accept;
         if (w_load_accept) begin
            r_load_row <= i_pos;
         end
         if (r_load_pending) begin
            r_working[r_load_row]     <= i_mem_rd_data;
            r_loaded_mask[r_load_row] <= 1'b1;
         end
         if (w_load_drop | w_run_drop) begin
            r_overrun <= 1'b1;
         end

         case (r_state)
            ST_FILL: begin
               if (r_loaded_mask == {ROWS{1'b1}}) begin
                  r_state       <= ST_READY;
                  r_board_valid <= 1'b1;
               end
            end
            ST_READY: begin
               // A run that overlaps an in-flight load waits for the capture
               if (i_run | r_run_hold) begin
                  if (r_load_pending | w_load_accept) begin
                     r_run_hold <= 1'b1;
                  end else begin
                     r_run_hold <= 1'b0;
                     r_state    <= ST_COMPUTE;
                     r_col      <= {COL_W{1'b0}};
                     r_busy     <= 1'b1;
                  end
               end
            end
            ST_COMPUTE: begin
               for (int r = 0; r < ROWS; r++) begin
                  r_next[r][r_col] <= w_next_col[r];
               end
               if (r_col == COL_W'(COLS - 1)) begin
                  r_state   <= ST_COMMIT;
                  r_pending <= {ROWS{1'b1}};
                  r_col     <= {COL_W{1'b0}};
               end else begin
                  r_col <= r_col + COL_W'(1);
               end
            end
            ST_COMMIT: begin
               if (w_commit_hit) begin
                  r_working[i_pos] <= r_next[i_pos];
                  r_pending        <= w_pending_after;
                  if (w_pending_after == {ROWS{1'b0}}) begin
                     r_gen_count <= r_gen_count + GEN_W'(1);
                     r_state     <= ST_READY;
                     r_busy      <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_life_gen_engine.sv
// Self-checking bench for life_gen_engine: directed scenarios plus random
// boards, checked against an array-based Game-of-Life reference model.
module tb_life_gen_engine;

   localparam int COLS  = 16;
   localparam int GEN_W = 16;

   logic             clk;
   logic             reset;
   logic             write_array;
   logic             run;
   logic [1:0]       pos;
   logic             write_mem;
   logic [1:0]       mem_addr;
   logic [COLS-1:0]  mem_rd_data;
   logic             mem_wr_en;
   logic [COLS-1:0]  mem_wr_data;
   logic             board_valid;
   logic             busy;
   logic             overrun;
   logic [GEN_W-1:0] gen_count;

   int               vectors;
   int               miscompares;
   int               exp_gen;
   logic [COLS-1:0]  src     [4];
   logic [COLS-1:0]  model_b [4];
   logic [COLS-1:0]  model_n [4];
   int               order   [4];

   life_gen_engine #(.COLS(COLS), .GEN_W(GEN_W)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_write_array (write_array),
      .i_run         (run),
      .i_pos         (pos),
      .i_write_mem   (write_mem),
      .o_mem_addr    (mem_addr),
      .i_mem_rd_data (mem_rd_data),
      .o_mem_wr_en   (mem_wr_en),
      .o_mem_wr_data (mem_wr_data),
      .o_board_valid (board_valid),
      .o_busy        (busy),
      .o_overrun     (overrun),
      .o_gen_count   (gen_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Board RAM read side: synchronous, one cycle of latency
   always @(posedge clk) mem_rd_data <= src[mem_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: next generation straight from the rules on a 4 x COLS torus
   task automatic compute_model();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < COLS; c++) begin
            int cnt;
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr != 0 || dc != 0) begin
                     cnt += int'(model_b[(r + dr + 4) % 4][(c + dc + COLS) % COLS]);
                  end
               end
            end
            model_n[r][c] = (cnt == 3) || (model_b[r][c] && cnt == 2);
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      exp_gen = 0;
      tick();
   endtask

   task automatic load_board(input logic [COLS-1:0] r0, input logic [COLS-1:0] r1,
                             input logic [COLS-1:0] r2, input logic [COLS-1:0] r3);
      src[0] = r0; src[1] = r1; src[2] = r2; src[3] = r3;
      for (int p = 0; p < 4; p++) begin
         pos = 2'(p);
         write_array = 1'b1;
         tick();
         write_array = 1'b0;
         tick();
      end
      tick();
      for (int p = 0; p < 4; p++) model_b[p] = src[p];
   endtask

   task automatic run_gen(input bit inject_run, input bit shuffle);
      compute_model();
      for (int i = 0; i < 4; i++) order[i] = i;
      if (shuffle) begin
         for (int i = 3; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = order[i]; order[i] = order[j]; order[j] = t;
         end
      end
      run = 1'b1;
      tick();
      for (int k = 0; k < COLS - 1; k++) begin
         run = (inject_run && k == 5) ? 1'b1 : 1'b0;
         check("busy_compute", 32'(busy), 32'd1);
         tick();
      end
      run = 1'b0;
      check("busy_compute", 32'(busy), 32'd1);
      pos = 2'(order[0]);
      write_mem = 1'b1;
      #1;
      check("latency_no_wr", 32'(mem_wr_en), 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         pos = 2'(order[i]);
         write_mem = 1'b1;
         #1;
         check("commit_wr_en", 32'(mem_wr_en), 32'd1);
         check("commit_wr_data", 32'(mem_wr_data), 32'(model_n[order[i]]));
         check("busy_commit", 32'(busy), 32'd1);
         tick();
         check("repeat_or_ready_no_wr", 32'(mem_wr_en), 32'd0);
      end
      write_mem = 1'b0;
      exp_gen++;
      check("gen_count", 32'(gen_count), 32'(exp_gen));
      check("busy_idle", 32'(busy), 32'd0);
      for (int p = 0; p < 4; p++) model_b[p] = model_n[p];
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      exp_gen = 0;
      reset = 1'b1;
      write_array = 1'b0;
      run = 1'b0;
      pos = 2'd0;
      write_mem = 1'b0;
      for (int p = 0; p < 4; p++) src[p] = '0;

      // Reset state
      tick();
      tick();
      check("rst_board_valid", 32'(board_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_gen_count", 32'(gen_count), 32'd0);
      check("rst_wr_en", 32'(mem_wr_en), 32'd0);
      reset = 1'b0;
      tick();

      // run in FILL is ignored without raising overrun
      run = 1'b1;
      tick();
      run = 1'b0;
      tick();
      check("fill_run_busy", 32'(busy), 32'd0);
      check("fill_run_overrun", 32'(overrun), 32'd0);

      // Fill sweep: board_valid rises the cycle after the 4th capture
      src[0] = 16'h0001; src[1] = 16'h0002; src[2] = 16'h0004; src[3] = 16'h0008;
      for (int p = 0; p < 4; p++) begin
         pos = 2'(p);
         write_array = 1'b1;
         tick();
         write_array = 1'b0;
         check("fill_valid_low", 32'(board_valid), 32'd0);
         tick();
         check("fill_valid_low_cap", 32'(board_valid), 32'd0);
      end
      tick();
      check("fill_valid_high", 32'(board_valid), 32'd1);
      for (int p = 0; p < 4; p++) model_b[p] = src[p];
      // write_mem in READY must not write
      pos = 2'd1;
      write_mem = 1'b1;
      #1;
      check("ready_wm_no_wr", 32'(mem_wr_en), 32'd0);
      tick();
      write_mem = 1'b0;
      run_gen(1'b0, 1'b0);

      // Blinker oscillates with period 2
      do_reset();
      load_board(16'h0000, 16'h0070, 16'h0000, 16'h0000);
      run_gen(1'b0, 1'b0);
      check("blinker_g1_row1", 32'(model_b[1]), 32'h0000_0020);
      run_gen(1'b0, 1'b0);
      check("blinker_g2_row1", 32'(model_b[1]), 32'h0000_0070);

      // 2x2 block is a still life
      do_reset();
      load_board(16'h0000, 16'h0180, 16'h0180, 16'h0000);
      for (int g = 0; g < 3; g++) run_gen(1'b0, 1'b0);

      // Corner cells across both wrap seams
      do_reset();
      load_board(16'h8001, 16'h0000, 16'h0000, 16'h0001);
      run_gen(1'b0, 1'b0);

      // run during COMPUTE is dropped, result unaffected
      do_reset();
      load_board(16'h0000, 16'h0070, 16'h0000, 16'h0000);
      run_gen(1'b1, 1'b0);
      check("overrun_set", 32'(overrun), 32'd1);

      // Random boards, reloaded in READY, shuffled commit order
      do_reset();
      for (int b = 0; b < 6; b++) begin
         load_board(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         run_gen(1'b0, 1'b1);
         run_gen(1'b0, 1'b1);
      end
      check("random_no_overrun", 32'(overrun), 32'd0);

      // Async reset in the middle of COMMIT
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int k = 0; k < COLS; k++) tick();
      for (int p = 0; p < 2; p++) begin
         pos = 2'(p);
         write_mem = 1'b1;
         tick();
      end
      pos = 2'd2;
      #1;
      check("pre_reset_wr_en", 32'(mem_wr_en), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_commit_wr_en", 32'(mem_wr_en), 32'd0);
      check("mid_commit_valid", 32'(board_valid), 32'd0);
      check("mid_commit_busy", 32'(busy), 32'd0);
      check("mid_commit_gen", 32'(gen_count), 32'd0);
      tick();
      write_mem = 1'b0;
      reset = 1'b0;
      tick();
      check("post_reset_valid", 32'(board_valid), 32'd0);
      check("post_reset_gen", 32'(gen_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
